// File: rtl/i2c_seg7_pkg.sv
// Shared definitions for the I2C seven-segment slave: FSM state codes,
// the digit register layout, the blank pattern and the hex font.
package i2c_seg7_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_PTR       = 4'd3;
  localparam state_t ST_PTR_ACK   = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RDATA     = 4'd7;
  localparam state_t ST_RDATA_ACK = 4'd8;
  localparam state_t ST_WAIT_STOP = 4'd9;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, value: 4'h0};

  // Segment a is bit 0, g is bit 6; lower-case b and d keep them distinct from 8 and 0
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/i2c_seg7_slave_enc.sv
// Combinational digit encoder: hex value plus blank flag to segment pattern.
module seg7_enc
  import i2c_seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : hex_font(value);

endmodule

// File: rtl/i2c_seg7_slave.sv
// I2C slave owning N_DIGITS seven-segment digit registers.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
// Optional register read-back is compiled in when I2C_SEG7_READ_EN is defined.
module i2c_seg7_slave
  import i2c_seg7_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         N_DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [7*N_DIGITS-1:0] led,
  output logic                  wr_strobe
);

  localparam int PW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [6:0]      shift;
  logic [7:0]      rx_byte;
  logic            ack_on;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_next;
  digit_t          regs [N_DIGITS];
  logic [7*N_DIGITS-1:0] seg_all;

`ifdef I2C_SEG7_READ_EN
  logic       rw;
  logic       master_ack;
  logic [7:0] tx_shift;
  logic [7:0] rd_byte;
  assign rd_byte = {3'b000, regs[ptr].blank, regs[ptr].value};
`endif

  // Two-flop synchroniser followed by an edge register for both bus lines
  always_ff @(posedge clk) begin
    scl_s1 <= scl_i;
    scl_s2 <= scl_s1;
    scl_d  <= scl_s2;
    sda_s1 <= sda_i;
    sda_s2 <= sda_s1;
    sda_d  <= sda_s2;
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = ~sda_s2 & sda_d & scl_s2 & scl_d;
  assign stop_det  = sda_s2 & ~sda_d & scl_s2 & scl_d;
  assign rx_byte   = {shift, sda_s2};
  assign ptr_next  = (ptr == PW'(N_DIGITS - 1)) ? '0 : ptr + PW'(1);

  // Protocol FSM: byte reception, ACK driving, register writes and read-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ack_on    <= 1'b0;
      sda_oe    <= 1'b0;
      ptr       <= '0;
      wr_strobe <= 1'b0;
      for (int k = 0; k < N_DIGITS; k++) regs[k] <= DIGIT_RESET;
`ifdef I2C_SEG7_READ_EN
      rw         <= 1'b0;
      master_ack <= 1'b0;
      tx_shift   <= '0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        ack_on  <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] != SLAVE_ADDR) begin
                    state <= ST_IDLE;
                  end else begin
`ifdef I2C_SEG7_READ_EN
                    rw    <= rx_byte[0];
                    state <= ST_ADDR_ACK;
`else
                    state <= rx_byte[0] ? ST_IDLE : ST_ADDR_ACK;
`endif
                  end
                end else if (state == ST_PTR) begin
                  if (rx_byte < 8'(N_DIGITS)) begin
                    ptr   <= rx_byte[PW-1:0];
                    state <= ST_PTR_ACK;
                  end else begin
                    state <= ST_IDLE;
                  end
                end else begin
                  regs[ptr] <= '{blank: rx_byte[4], value: rx_byte[3:0]};
                  wr_strobe <= 1'b1;
                  ptr       <= ptr_next;
                  state     <= ST_WDATA_ACK;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                if (state == ST_ADDR_ACK) begin
`ifdef I2C_SEG7_READ_EN
                  if (rw) begin
                    state    <= ST_RDATA;
                    bit_cnt  <= '0;
                    sda_oe   <= ~rd_byte[7];
                    tx_shift <= {rd_byte[6:0], 1'b0};
                  end else begin
                    state <= ST_PTR;
                  end
`else
                  state <= ST_PTR;
`endif
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end
`ifdef I2C_SEG7_READ_EN
          ST_RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                ptr     <= ptr_next;
                state   <= ST_RDATA_ACK;
              end else begin
                sda_oe   <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) master_ack <= ~sda_s2;
            if (scl_fall) begin
              if (master_ack) begin
                state    <= ST_RDATA;
                bit_cnt  <= '0;
                sda_oe   <= ~rd_byte[7];
                tx_shift <= {rd_byte[6:0], 1'b0};
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WAIT_STOP;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    seg7_enc u_enc (
      .value(regs[k].value),
      .blank(regs[k].blank),
      .seg  (seg_all[7*k +: 7])
    );
  end

  // Register the encoded patterns so the LED pins change cleanly one cycle after a write
  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= seg_all;
  end

endmodule

// File: tb/tb_i2c_seg7_slave.sv
// Self-checking bench for i2c_seg7_slave: bit-banged I2C master, a table of
// directed write transactions, hand-written corner sequences and randomized
// writes checked against a register-bank model. Define I2C_SEG7_READ_EN for read-back.
module tb_i2c_seg7_slave;

  localparam int N = 4;
  localparam int Q = 10;
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, wr_strobe;
  logic [7*N-1:0] led;
  logic sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_seg7_slave #(.SLAVE_ADDR(7'h3C), .N_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus),
    .sda_oe(sda_oe), .led(led), .wr_strobe(wr_strobe)
  );

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;

  // Count write strobes sampled away from the active edge
  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  logic       m_blank [N];
  logic [3:0] m_value [N];

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  ptr;
    int          n;
    logic [31:0] data;
    logic        aack;
    logic        pack;
    int          strb;
    logic [27:0] led;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    ack = ~sda_bus;
    wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    b = '0;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q();
      scl = 1'b1; wait_q();
      b[i] = sda_bus;
      wait_q();
      scl = 1'b0; wait_q();
    end
    sda_m = ~mack; wait_q();
    scl = 1'b1;    wait_q(); wait_q();
    scl = 1'b0;    wait_q();
    sda_m = 1'b1;
  endtask

  function automatic logic [27:0] model_led();
    logic [27:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[7*k +: 7] = m_blank[k] ? 7'h00 : FONT[m_value[k]];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_blank[k] = 1'b1;
      m_value[k] = 4'h0;
    end
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [7:0] ptr, input int n,
                             input logic [31:0] data, output logic eaack, output logic epack,
                             output int estrb);
    int p;
    logic [7:0] d;
    eaack = (addr[7:1] == 7'h3C) && (addr[0] == 1'b0);
    epack = 1'b0;
    estrb = 0;
    if (eaack) begin
      epack = (ptr < N);
      if (epack) begin
        p = int'(ptr);
        for (int i = 0; i < n; i++) begin
          d = data[8*i +: 8];
          m_blank[p] = d[4];
          m_value[p] = d[3:0];
          p = (p + 1) % N;
          estrb++;
        end
      end
    end
  endtask

  // Full bus transaction: START, address, pointer, data bytes, optional STOP
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] ptr, input int n,
                               input logic [31:0] data, input logic do_stop,
                               output logic aack, output logic pack, output int dacks,
                               output int strb);
    int s0;
    logic a;
    s0 = strobe_cnt;
    pack = 1'b0;
    dacks = 0;
    i2c_start();
    write_byte(addr, aack);
    if (aack) begin
      write_byte(ptr, pack);
      if (pack) begin
        for (int i = 0; i < n; i++) begin
          write_byte(data[8*i +: 8], a);
          if (a) dacks++;
        end
      end
    end
    if (do_stop) i2c_stop();
    repeat (5) @(negedge clk);
    strb = strobe_cnt - s0;
  endtask

  logic ack, eaack, epack, pack;
  int dacks, strb, estrb;
  logic [7:0] rb;
  logic [7:0] ra, rp;
  int rn;
  logic [31:0] rdata;

  initial begin
    model_reset();
    vecs[0] = '{addr: 8'h78, ptr: 8'h01, n: 1, data: 32'h05,   aack: 1'b1, pack: 1'b1, strb: 1,
                led: {7'h00, 7'h00, 7'h6D, 7'h00}};
    vecs[1] = '{addr: 8'h78, ptr: 8'h03, n: 2, data: 32'h0B0A, aack: 1'b1, pack: 1'b1, strb: 2,
                led: {7'h77, 7'h00, 7'h6D, 7'h7C}};
    vecs[2] = '{addr: 8'h7A, ptr: 8'h01, n: 1, data: 32'h07,   aack: 1'b0, pack: 1'b0, strb: 0,
                led: {7'h77, 7'h00, 7'h6D, 7'h7C}};
    vecs[3] = '{addr: 8'h78, ptr: 8'h04, n: 1, data: 32'h07,   aack: 1'b1, pack: 1'b0, strb: 0,
                led: {7'h77, 7'h00, 7'h6D, 7'h7C}};
    vecs[4] = '{addr: 8'h78, ptr: 8'h02, n: 1, data: 32'h2E,   aack: 1'b1, pack: 1'b1, strb: 1,
                led: {7'h77, 7'h79, 7'h6D, 7'h7C}};
    vecs[5] = '{addr: 8'h78, ptr: 8'h00, n: 2, data: 32'h0610, aack: 1'b1, pack: 1'b1, strb: 2,
                led: {7'h77, 7'h79, 7'h7D, 7'h00}};

    // Reset state
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_led", {4'h0, led}, 32'h0);
    checkOutput("reset_sda_oe", {31'h0, sda_oe}, 32'h0);
    checkOutput("reset_wr_strobe", {31'h0, wr_strobe}, 32'h0);

    // Traffic without START is ignored
    scl = 1'b0; wait_q();
    write_byte(8'h78, ack);
    checkOutput("no_start_ack", {31'h0, ack}, 32'h0);
    i2c_stop();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].ptr, vecs[i].n, vecs[i].data, 1'b1, ack, pack, dacks, strb);
      model_write(vecs[i].addr, vecs[i].ptr, vecs[i].n, vecs[i].data, eaack, epack, estrb);
      checkOutput($sformatf("vec%0d_addr_ack", i), {31'h0, ack}, {31'h0, vecs[i].aack});
      checkOutput($sformatf("vec%0d_ptr_ack", i), {31'h0, pack}, {31'h0, vecs[i].pack});
      checkOutput($sformatf("vec%0d_strobes", i), strb, vecs[i].strb);
      checkOutput($sformatf("vec%0d_led", i), {4'h0, led}, {4'h0, vecs[i].led});
    end

    // STOP after four data bits drops the partial byte; repeated START write commits
    strb = strobe_cnt;
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    repeat (5) @(negedge clk);
    checkOutput("partial_led", {4'h0, led}, {4'h0, model_led()});
    applyStimulus(8'h78, 8'h03, 1, 32'h08, 1'b0, ack, pack, dacks, estrb);
    model_write(8'h78, 8'h03, 1, 32'h08, eaack, epack, estrb);
    applyStimulus(8'h78, 8'h01, 1, 32'h09, 1'b1, ack, pack, dacks, estrb);
    model_write(8'h78, 8'h01, 1, 32'h09, eaack, epack, estrb);
    checkOutput("partial_strobes", strobe_cnt - strb, 2);
    checkOutput("rep_start_led", {4'h0, led}, {4'h0, model_led()});

`ifdef I2C_SEG7_READ_EN
    // Read back digits 1 and 2 after setting the pointer
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'h79, ack);
    checkOutput("read_addr_ack", {31'h0, ack}, 32'h1);
    read_byte(1'b1, rb);
    checkOutput("read_byte0", {24'h0, rb}, {27'h0, m_blank[1], m_value[1]});
    read_byte(1'b0, rb);
    checkOutput("read_byte1", {24'h0, rb}, {27'h0, m_blank[2], m_value[2]});
    checkOutput("read_nack_release", {31'h0, sda_oe}, 32'h0);
    i2c_stop();
`else
    // Read request is refused without read-back
    i2c_start();
    write_byte(8'h79, ack);
    checkOutput("read_addr_nack", {31'h0, ack}, 32'h0);
    i2c_stop();
`endif

    // Reset mid-transaction: SDA released, registers cleared, bus ignored until START
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    checkOutput("midreset_sda_oe", {31'h0, sda_oe}, 32'h0);
    checkOutput("midreset_led", {4'h0, led}, 32'h0);
    write_byte(8'h78, ack);
    checkOutput("midreset_no_start_ack", {31'h0, ack}, 32'h0);
    i2c_stop();

    // Randomized writes against the model
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0, 1:    ra = 8'h78;
        2:       ra = 8'h7A;
        default: ra = {7'($urandom_range(0, 127)), 1'b0};
      endcase
      rp = 8'($urandom_range(0, 5));
      rn = $urandom_range(0, 3);
      rdata = $urandom;
      applyStimulus(ra, rp, rn, rdata, 1'b1, ack, pack, dacks, strb);
      model_write(ra, rp, rn, rdata, eaack, epack, estrb);
      checkOutput($sformatf("rnd%0d_addr_ack", it), {31'h0, ack}, {31'h0, eaack});
      checkOutput($sformatf("rnd%0d_ptr_ack", it), {31'h0, pack}, {31'h0, epack});
      checkOutput($sformatf("rnd%0d_data_acks", it), dacks, estrb);
      checkOutput($sformatf("rnd%0d_strobes", it), strb, estrb);
      checkOutput($sformatf("rnd%0d_led", it), {4'h0, led}, {4'h0, model_led()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
